// File: rtl/reg_dump_sequencer_if.sv
// Debug-dump bundle: register-bank read port on one side, byte
// transmitter handshake on the other.
interface reg_dump_sequencer_if #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_BYTE = 8
);
    logic               i_start;
    logic [NB_DATA-1:0] i_rb_data;
    logic               i_tx_done;
    logic               o_rb_enable;
    logic               o_rb_read_enable;
    logic [NB_REG-1:0]  o_rb_read_addr;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_done;

    modport master (
        input  i_start,
        input  i_rb_data,
        input  i_tx_done,
        output o_rb_enable,
        output o_rb_read_enable,
        output o_rb_read_addr,
        output o_tx_data,
        output o_tx_start,
        output o_busy,
        output o_done
    );

    modport slave (
        output i_start,
        output i_rb_data,
        output i_tx_done,
        input  o_rb_enable,
        input  o_rb_read_enable,
        input  o_rb_read_addr,
        input  o_tx_data,
        input  o_tx_start,
        input  o_busy,
        input  o_done
    );
endinterface

// File: rtl/reg_dump_sequencer.sv
// Walks the register bank and streams every word out to the
// transmitter one byte at a time, LSB first.
module reg_dump_sequencer #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_BYTE = 8,
    parameter int N_REGS  = 32
) (
    input logic                  i_clock,
    input logic                  i_reset,
    reg_dump_sequencer_if.master bus
);
    localparam int NBYTES = NB_DATA / NB_BYTE;
    localparam int NB_BC  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [NB_BC-1:0]  LAST_BYTE = NB_BC'(NBYTES - 1);
    localparam logic [NB_REG-1:0] LAST_REG  = NB_REG'(N_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        SEND,
        WAIT_TX,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NB_REG-1:0]  reg_cnt;
    logic [NB_BC-1:0]   byte_cnt;
    logic [NB_DATA-1:0] shadow;
    logic [NB_BYTE-1:0] tx_byte;
    logic               last_byte;
    logic               last_reg;

    assign last_byte = (byte_cnt == LAST_BYTE);
    assign last_reg  = (reg_cnt == LAST_REG);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= IDLE;
            reg_cnt  <= '0;
            byte_cnt <= '0;
            shadow   <= '0;
        end else begin
            state <= state_next;
            case (state)
                CAPTURE: begin
                    shadow   <= bus.i_rb_data;
                    byte_cnt <= '0;
                end
                WAIT_TX: begin
                    if (bus.i_tx_done) begin
                        if (!last_byte) begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end else if (!last_reg) begin
                            reg_cnt <= reg_cnt + 1'b1;
                        end
                    end
                end
                DONE: reg_cnt <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.i_start) state_next = READ;
            READ:    state_next = CAPTURE;
            CAPTURE: state_next = SEND;
            SEND:    state_next = WAIT_TX;
            WAIT_TX: begin
                if (bus.i_tx_done) begin
                    if (!last_byte) begin
                        state_next = SEND;
                    end else if (!last_reg) begin
                        state_next = READ;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shadow and byte counter only move in CAPTURE/WAIT_TX, so the
    // presented byte stays put from SEND until its tx_done.
    always_comb begin
        tx_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_cnt == NB_BC'(i)) begin
                tx_byte = shadow[i*NB_BYTE +: NB_BYTE];
            end
        end
    end

    assign bus.o_rb_enable      = (state == READ);
    assign bus.o_rb_read_enable = (state == READ);
    assign bus.o_rb_read_addr   = reg_cnt;
    assign bus.o_tx_data        = tx_byte;
    assign bus.o_tx_start       = (state == SEND);
    assign bus.o_busy           = (state != IDLE);
    assign bus.o_done           = (state == DONE);
endmodule
